rom_bank_sel_pipe: RTL and testbench

- Parametrised, registered successor to the combinational ROM-bank output selector in the convolution datapath.
- Selects one of NUM_SRC filter/ROM words of DATA_W bits and presents it through a single pipeline register with valid/ready handshake.
- Two modes:
  - Direct: the selector is driven per beat.
  - Sweep: the block itself steps through banks 0..N for one output feature pass.
- Sits between the ROM banks and the convolution MAC array.

---
 rtl/rom_bank_sel_pipe_if.sv | 26 ++
 rtl/rom_bank_sel_pipe.sv | 139 +++++++++++++
 tb/tb_rom_bank_sel_pipe.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/rom_bank_sel_pipe_if.sv
// Bus between the ROM banks and the MAC array: flattened source words in,
// one selected word out, each side with a valid/ready handshake.
interface rom_bank_sel_pipe_if #(
    parameter int DATA_W  = 192,
    parameter int NUM_SRC = 8,
    parameter int SEL_W   = $clog2(NUM_SRC)
);
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [SEL_W-1:0]          sel;
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output src_data, sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
        input  src_data, sel, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/rom_bank_sel_pipe.sv
// Registered ROM-bank selector: one pipeline stage with valid/ready, either
// steered per beat by sel (direct) or stepping banks 0..last itself (sweep).
module rom_bank_sel_pipe #(
    parameter int DATA_W  = 192,
    parameter int NUM_SRC = 8,
    parameter int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             seq_start,
    input  logic [SEL_W-1:0] seq_last,
    output logic             sel_err,
    output logic             seq_busy,
    output logic             seq_done,
    rom_bank_sel_pipe_if.slave bus
);
    typedef enum logic {IDLE, SWEEP} state_t;

    localparam logic [SEL_W-1:0] MAX_IDX   = SEL_W'(NUM_SRC - 1);
    localparam logic [SEL_W:0]   NUM_SRC_W = (SEL_W + 1)'(NUM_SRC);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  last_q, last_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;
    logic              out_valid_q, out_valid_d;
    logic              sel_err_q, sel_err_d;
    logic              seq_busy_q, seq_busy_d;
    logic              seq_done_q, seq_done_d;

    logic [DATA_W-1:0] bank [NUM_SRC];
    logic [DATA_W-1:0] sel_word;
    logic [SEL_W-1:0]  idx;
    logic              mode_ok;
    logic              in_ready_c;
    logic              accept;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_bank
            assign bank[gi] = bus.src_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        idx        = (state_q == SWEEP) ? cnt_q : bus.sel;
        mode_ok    = mode_q ? seq_busy_q : 1'b1;
        in_ready_c = mode_ok && (!out_valid_q || bus.out_ready);
        accept     = bus.in_valid && in_ready_c;

        // An out-of-range index matches no bank, so the word falls out as zero.
        sel_word = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (idx == SEL_W'(k)) sel_word = bank[k];
        end

        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        mode_d      = mode_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        sel_err_d   = 1'b0;
        seq_busy_d  = seq_busy_q;
        seq_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                mode_d = mode;
                if (mode && seq_start) begin
                    last_d     = (seq_last > MAX_IDX) ? MAX_IDX : seq_last;
                    cnt_d      = '0;
                    state_d    = SWEEP;
                    seq_busy_d = 1'b1;
                end
            end
            SWEEP: begin
                if (accept) begin
                    if (cnt_q == last_q) begin
                        cnt_d      = '0;
                        seq_done_d = 1'b1;
                        state_d    = IDLE;
                        seq_busy_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            out_data_d  = sel_word;
            out_sel_d   = idx;
            out_valid_d = 1'b1;
            sel_err_d   = (state_q == IDLE) && ({1'b0, bus.sel} >= NUM_SRC_W);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= '0;
            mode_q      <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            seq_busy_q  <= 1'b0;
            seq_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            mode_q      <= mode_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            seq_busy_q  <= seq_busy_d;
            seq_done_q  <= seq_done_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_valid = out_valid_q;
    assign sel_err       = sel_err_q;
    assign seq_busy      = seq_busy_q;
    assign seq_done      = seq_done_q;
endmodule

// File: tb/tb_rom_bank_sel_pipe.sv
// Directed bench: an 8-bank and a 6-bank instance exercised with
// hand-computed bank words, backpressure, sweeps, clamping and reset.
module tb_rom_bank_sel_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic r8, r6;
    logic mode8, start8, err8, busy8, done8;
    logic mode6, start6, err6, busy6, done6;
    logic [2:0] last8, last6;

    rom_bank_sel_pipe_if #(.DATA_W(192), .NUM_SRC(8)) b8 ();
    rom_bank_sel_pipe_if #(.DATA_W(192), .NUM_SRC(6)) b6 ();

    rom_bank_sel_pipe #(.DATA_W(192), .NUM_SRC(8)) dut8 (
        .clk(clk), .rst_n(r8), .mode(mode8), .seq_start(start8), .seq_last(last8),
        .sel_err(err8), .seq_busy(busy8), .seq_done(done8), .bus(b8)
    );
    rom_bank_sel_pipe #(.DATA_W(192), .NUM_SRC(6)) dut6 (
        .clk(clk), .rst_n(r6), .mode(mode6), .seq_start(start6), .seq_last(last6),
        .sel_err(err6), .seq_busy(busy6), .seq_done(done6), .bus(b6)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [191:0] bank_word(input int k);
        logic [191:0] w;
        for (int i = 0; i < 24; i++) w[i*8 +: 8] = 8'(8'h10 + k);
        return w;
    endfunction

    initial begin
        r8 = 1'b0; r6 = 1'b0;
        mode8 = 1'b0; start8 = 1'b0; last8 = '0;
        mode6 = 1'b0; start6 = 1'b0; last6 = '0;
        b8.sel = '0; b8.in_valid = 1'b0; b8.out_ready = 1'b0;
        b6.sel = '0; b6.in_valid = 1'b0; b6.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) b8.src_data[k*192 +: 192] = bank_word(k);
        for (int k = 0; k < 6; k++) b6.src_data[k*192 +: 192] = bank_word(k);

        // Reset state
        #3;
        chk("rst_out_valid", b8.out_valid, 0);
        chk("rst_out_data", b8.out_data, 0);
        chk("rst_out_sel", b8.out_sel, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_err", err8, 0);
        #9;
        r8 = 1'b1; r6 = 1'b1;

        // Direct select of every bank back to back
        b8.out_ready = 1'b1;
        b8.in_valid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            b8.sel = 3'(k);
            #1;
            chk("dir_in_ready", b8.in_ready, 1);
            tick();
            chk("dir_data", b8.out_data, bank_word(k));
            chk("dir_sel", b8.out_sel, k);
            chk("dir_valid", b8.out_valid, 1);
            $display("[TB] direct sel=%0d out_sel=%0d", k, b8.out_sel);
        end
        b8.in_valid = 1'b0;
        tick();
        chk("dir_drain", b8.out_valid, 0);

        // Backpressure: bank 3 holds while bank 5 waits
        b8.sel = 3'd3; b8.in_valid = 1'b1;
        tick();
        chk("bp_load3", b8.out_data, bank_word(3));
        b8.sel = 3'd5; b8.out_ready = 1'b0;
        #1;
        chk("bp_ready0", b8.in_ready, 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("bp_hold_data", b8.out_data, bank_word(3));
            chk("bp_hold_sel", b8.out_sel, 3);
            chk("bp_hold_valid", b8.out_valid, 1);
            chk("bp_hold_ready", b8.in_ready, 0);
            $display("[TB] stall cycle %0d out_sel=%0d", c, b8.out_sel);
        end
        b8.out_ready = 1'b1;
        #1;
        chk("bp_ready1", b8.in_ready, 1);
        tick();
        chk("bp_load5_data", b8.out_data, bank_word(5));
        chk("bp_load5_sel", b8.out_sel, 5);
        chk("bp_load5_valid", b8.out_valid, 1);
        b8.in_valid = 1'b0;
        tick();
        chk("bp_drain", b8.out_valid, 0);

        // Auto sweep 0..3
        mode8 = 1'b1;
        tick();
        chk("sw_idle_ready", b8.in_ready, 0);
        start8 = 1'b1; last8 = 3'd3;
        tick();
        start8 = 1'b0;
        chk("sw_busy", busy8, 1);
        chk("sw_ready", b8.in_ready, 1);
        b8.in_valid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            tick();
            chk("sw_sel", b8.out_sel, b);
            chk("sw_data", b8.out_data, bank_word(b));
            chk("sw_done", done8, (b == 3) ? 1 : 0);
            chk("sw_busy_beat", busy8, (b == 3) ? 0 : 1);
            $display("[TB] sweep beat %0d out_sel=%0d done=%0d", b, b8.out_sel, done8);
        end
        chk("sw_after_ready", b8.in_ready, 0);
        tick();
        chk("sw_done_once", done8, 0);
        chk("sw_no_extra", b8.out_valid, 0);
        b8.in_valid = 1'b0;

        // Clamped sweep on the 6-bank instance
        mode6 = 1'b1; b6.out_ready = 1'b1; b6.in_valid = 1'b1;
        tick();
        start6 = 1'b1; last6 = 3'd7;
        tick();
        start6 = 1'b0;
        for (int b = 0; b < 6; b++) begin
            tick();
            chk("clamp_sel", b6.out_sel, b);
            chk("clamp_done", done6, (b == 5) ? 1 : 0);
            $display("[TB] clamp beat %0d out_sel=%0d", b, b6.out_sel);
        end
        chk("clamp_ready", b6.in_ready, 0);
        tick();
        chk("clamp_stop", b6.out_valid, 0);

        // Degenerate one-beat sweep
        start6 = 1'b1; last6 = 3'd0;
        tick();
        start6 = 1'b0;
        tick();
        chk("one_sel", b6.out_sel, 0);
        chk("one_data", b6.out_data, bank_word(0));
        chk("one_valid", b6.out_valid, 1);
        chk("one_done", done6, 1);
        tick();
        chk("one_done_off", done6, 0);
        chk("one_single", b6.out_valid, 0);
        chk("one_busy", busy6, 0);
        $display("[TB] single-beat sweep out_sel=%0d", b6.out_sel);

        // Out-of-range direct select
        b6.in_valid = 1'b0; mode6 = 1'b0;
        tick();
        b6.sel = 3'd6; b6.in_valid = 1'b1;
        tick();
        b6.in_valid = 1'b0;
        chk("oor_data", b6.out_data, 0);
        chk("oor_sel", b6.out_sel, 6);
        chk("oor_valid", b6.out_valid, 1);
        chk("oor_err", err6, 1);
        tick();
        chk("oor_err_off", err6, 0);
        $display("[TB] out-of-range sel=6 handled");

        // Reset in the middle of a stalled sweep
        start8 = 1'b1; last8 = 3'd3;
        tick();
        start8 = 1'b0; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
        tick();
        tick();
        chk("mr_beat1", b8.out_sel, 1);
        b8.out_ready = 1'b0;
        #2;
        r8 = 1'b0;
        #1;
        chk("mr_valid", b8.out_valid, 0);
        chk("mr_busy", busy8, 0);
        chk("mr_done", done8, 0);
        b8.in_valid = 1'b0;
        tick();
        chk("mr_done_hold", done8, 0);
        #2;
        r8 = 1'b1;
        tick();
        start8 = 1'b1; last8 = 3'd3;
        tick();
        start8 = 1'b0; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
        chk("mr_done_none", done8, 0);
        tick();
        chk("mr_restart_sel", b8.out_sel, 0);
        chk("mr_restart_data", b8.out_data, bank_word(0));
        tick();
        chk("mr_next_sel", b8.out_sel, 1);
        $display("[TB] restart after reset out_sel=%0d", b8.out_sel);
        b8.in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
